// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and the captured-request record for dmem_ls.
package dmem_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Address is kept outside the record because its width is a module parameter.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic        err;
        logic [31:0] wdata;
    } req_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_H:    bad = lo[0];
            SZ_W:    bad = |lo;
            SZ_RSV:  bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM: byte-enable synchronous write, combinational read.
module dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [3:0][7:0] mem [DEPTH];

    // No reset: contents survive rst.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (be[l]) mem[addr][l] <= wdata[l*8 +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ls.sv
// Load/store front end: request capture, alignment check, wait-state FSM,
// byte-lane steering and load extension around a dmem_ram instance.
module dmem_ls
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [2:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    if (DEPTH != (1 << IDX_W)) begin : g_bad_depth
        $error("dmem_ls: DEPTH must equal 2**(ADDR_W-2)");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_bad_wait
        $error("dmem_ls: WAIT_CYCLES must be in 0..7");
    end

    state_t            state, state_nx;
    logic [2:0]        cnt, cnt_nx;
    req_t              rq, cur;
    logic [ADDR_W-1:0] rq_addr, cur_addr;
    logic [31:0]       rdata_q;
    logic              accept, in_err, go_resp;

    logic [1:0]  lane;
    logic [31:0] ram_rdata, shifted, load_val, ram_wdata;
    logic [3:0]  lane_be, ram_be;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign in_err    = misaligned(req_size, req_addr[1:0]);

    // In IDLE the request is still on the ports; afterwards it lives in rq.
    always_comb begin
        cur      = rq;
        cur_addr = rq_addr;
        if (state == IDLE) begin
            cur      = '{we: req_we, size: req_size, uns: req_unsigned,
                         err: in_err, wdata: req_wdata};
            cur_addr = req_addr;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        go_resp  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_err || WAIT_CYCLES == 0) begin
                        state_nx = RESP;
                        go_resp  = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_nx = RESP;
                    go_resp  = 1'b1;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Lane steering: little-endian, lane = addr[1:0].
    assign lane    = cur_addr[1:0];
    assign shifted = ram_rdata >> {lane, 3'b000};

    always_comb begin
        load_val  = ram_rdata;
        ram_wdata = cur.wdata;
        lane_be   = 4'b1111;
        case (cur.size)
            SZ_B: begin
                load_val  = cur.uns ? {24'd0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
                ram_wdata = {4{cur.wdata[7:0]}};
                lane_be   = 4'b0001 << lane;
            end
            SZ_H: begin
                load_val  = cur.uns ? {16'd0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
                ram_wdata = {2{cur.wdata[15:0]}};
                lane_be   = lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                load_val  = ram_rdata;
                ram_wdata = cur.wdata;
                lane_be   = 4'b1111;
            end
        endcase
    end

    // Store commits only on the edge entering RESP, so a reset in WAIT drops it.
    assign ram_be = (go_resp && cur.we && !cur.err) ? lane_be : 4'b0000;

    dmem_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .be    (ram_be),
        .addr  (cur_addr[ADDR_W-1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            rq      <= '0;
            rq_addr <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                rq      <= cur;
                rq_addr <= cur_addr;
            end
            if (go_resp) rdata_q <= (cur.we || cur.err) ? 32'd0 : load_val;
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid && rq.err;
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;

endmodule

// File: doc/dmem_ls.md
DMEM_LS -- requirements
Module: dmem_ls

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-address width.
REQ-002 SHALL have parameter DEPTH, default 1024, word count; DEPTH SHALL equal 2**(ADDR_W-2) (elaboration check).
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, range 0..7, extra access latency.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  block can accept a request.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-010 SHALL have port req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-011 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-012 SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-013 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-014 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  misaligned or reserved-size request; valid with rsp_valid.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge with req_valid && req_ready, capturing all req_* fields into registers.
REQ-018 SHALL flag an error when size=01 && addr[0]!=0, size=10 && addr[1:0]!=0, or size=11.
REQ-019 Error requests: IDLE -> RESP directly; no memory write; rsp_err=1, rsp_rdata=0 in RESP.
REQ-020 Valid requests: IDLE -> WAIT when WAIT_CYCLES>0 (down-counter loaded with WAIT_CYCLES-1), else IDLE -> RESP; WAIT -> RESP when counter is 0, otherwise decrement.
REQ-021 Valid store: memory write SHALL commit on the edge entering RESP; only the addressed byte lanes (little-endian, lane = addr[1:0]) change.
REQ-022 Valid load: rsp_rdata SHALL be the word at addr[ADDR_W-1:2] as sampled on the edge entering RESP, with lane extracted and sign/zero-extended per req_size/req_unsigned; word loads unextended.
REQ-023 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; no backpressure on the response.
REQ-024 Accept-to-rsp_valid latency SHALL be WAIT_CYCLES+1 cycles for valid requests and 1 cycle for errors.
REQ-025 Outside RESP, rsp_valid, rsp_err and rsp_rdata SHALL be 0.
REQ-026 req_valid while req_ready=0 SHALL be ignored (requester holds it); a request arriving in the RESP cycle is accepted in the following IDLE cycle.
REQ-027 Address wrap: word index SHALL be addr[ADDR_W-1:2]; all ADDR_W values are legal.

Reset
REQ-028 rst SHALL force IDLE, counter 0, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0 immediately.
REQ-029 Memory contents SHALL NOT be cleared by rst; a store aborted by rst before entering RESP SHALL not modify memory.

Structure
REQ-030 Package dmem_pkg SHALL hold the size encoding constants (SZ_B, SZ_H, SZ_W, SZ_RSV) and the FSM state type.
REQ-031 Sub-module dmem_ram SHALL hold the DEPTH x 32 array with 4-bit byte-enable synchronous write and combinational read; dmem_ls owns FSM, alignment check, lane steering, extension.

Verification
REQ-032 WAIT_CYCLES=1: store word 0xDEADBEEF @0x010, then load word @0x010 -> rsp_valid 2 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-033 Store byte 0x80 @0x013 over 0x11223344, load signed byte @0x013 -> 0xFFFFFF80; unsigned -> 0x00000080; load word -> 0x80223344.
REQ-034 Load half @0x011 -> rsp_valid after 1 cycle, err=1, rdata=0; store size=11 @0x020 -> err=1, word @0x020 unchanged.
REQ-035 WAIT_CYCLES=3: back-to-back held req_valid -> req_ready low 4 cycles per access, second request accepted the cycle after RESP.
REQ-036 Assert rst in WAIT of store 0x12345678 @0x040 (prior 0x0) -> outputs zero at once, later load @0x040 -> 0x00000000.
REQ-037 Store @0xFFC then load @0xFFC (ADDR_W=12) -> word index 1023 written and read back; no aliasing to index 0.
